// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter and the IF/MEM stages.
// Contents:
//   - default address/data widths used by the pipeline stages
//   - arbiter FSM state enum
//   - grant decision enum and the fixed-priority pick function
package unified_mem_arbiter_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_MAX_DATA_BURST = 4;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_DATA_BUSY,
        ARB_FETCH_BUSY,
        ARB_DATA_RESP,
        ARB_FETCH_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_DATA
    } arb_gnt_t;

    // Data normally wins. A fetch that has been passed over too many
    // times (force_if) wins over data so the front end cannot starve.
    function automatic arb_gnt_t arb_pick(input logic force_if,
                                          input logic data_pend,
                                          input logic if_req);
        arb_gnt_t g;
        g = GNT_NONE;
        if (force_if)       g = GNT_FETCH;
        else if (data_pend) g = GNT_DATA;
        else if (if_req)    g = GNT_FETCH;
        return g;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_burst_counter.sv
// arb_burst_counter: saturating count of data grants made while a fetch
// was waiting.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one data grant (ignored once saturated)
//   clr        : clear to zero (wins over inc)
//   at_max     : count has reached MAX
module arb_burst_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between instruction
// fetch (IF) and load/store (MEM). One access is outstanding at a time.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   if_req/if_addr             : fetch request, held until if_ack
//   if_rdata/if_ack            : fetched word, one-cycle ack pulse
//   mem_rd/mem_wr/mem_addr/
//   mem_wdata                  : load/store request, held until mem_ack
//   mem_rdata/mem_ack          : load data, one-cycle ack pulse
//   freeze, stall_mem          : pipeline stalls while an access is pending
//   m_req/m_we/m_addr/m_wdata  : registered memory request, held to m_ready
//   m_rdata/m_ready            : memory read data and completion
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
    input  logic              clk,
    input  logic              reset,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    // data side
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    // pipeline control
    output logic              freeze,
    output logic              stall_mem,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    arb_state_t state;
    arb_gnt_t   gnt;
    logic       data_pend;
    logic       force_if;
    logic       burst_at_max;
    logic       burst_inc;
    logic       burst_clr;

    assign data_pend = mem_rd | mem_wr;
    assign force_if  = if_req & burst_at_max;

    // Grants are only decided in IDLE; requests are ignored elsewhere,
    // which is what keeps a request dropped in its ack cycle from being
    // granted twice.
    always_comb begin
        gnt = GNT_NONE;
        if (state == ARB_IDLE) gnt = arb_pick(force_if, data_pend, if_req);
    end

    // Only data grants that overtake a waiting fetch count toward the limit.
    assign burst_inc = (gnt == GNT_DATA) & if_req;
    assign burst_clr = (gnt == GNT_FETCH) | ((state == ARB_IDLE) & ~if_req);

    arb_burst_counter #(
        .MAX (MAX_DATA_BURST)
    ) u_burst (
        .clk    (clk),
        .reset  (reset),
        .inc    (burst_inc),
        .clr    (burst_clr),
        .at_max (burst_at_max)
    );

    // Stalls are combinational so the pipeline releases in the ack cycle.
    assign freeze    = if_req & ~if_ack;
    assign stall_mem = data_pend & ~mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt == GNT_FETCH) begin
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= if_addr;
                        state  <= ARB_FETCH_BUSY;
                    end else if (gnt == GNT_DATA) begin
                        // rd and wr together is a store; the read is dropped
                        m_req   <= 1'b1;
                        m_we    <= mem_wr;
                        m_addr  <= mem_addr;
                        m_wdata <= mem_wdata;
                        state   <= ARB_DATA_BUSY;
                    end
                end
                ARB_DATA_BUSY: begin
                    if (m_ready) begin
                        m_req   <= 1'b0;
                        mem_ack <= 1'b1;
                        if (!m_we) mem_rdata <= m_rdata;
                        state   <= ARB_DATA_RESP;
                    end
                end
                ARB_FETCH_BUSY: begin
                    if (m_ready) begin
                        m_req    <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= m_rdata;
                        state    <= ARB_FETCH_RESP;
                    end
                end
                ARB_DATA_RESP: begin
                    mem_ack <= 1'b0;
                    state   <= ARB_IDLE;
                end
                ARB_FETCH_RESP: begin
                    if_ack <= 1'b0;
                    state  <= ARB_IDLE;
                end
                default: begin
                    m_req   <= 1'b0;
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requester drivers and a memory
// responder run as independent processes; expected grants and ack data are
// queued when stimulus is issued and checked when the DUT produces them.
module tb_unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, mem_rd, mem_wr, mem_ack;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        freeze, stall_mem, m_req, m_we, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .freeze(freeze), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
    } gnt_t;

    dreq_t       dq[$];
    logic [31:0] fq[$];
    logic [31:0] fexp[$];
    logic [31:0] mexp[$];
    gnt_t        gexp[$];
    logic [31:0] mem [logic [31:0]];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_load = '0;
    int          mem_wait = 0;
    logic        auto_mem = 1'b1;
    logic        force_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    task automatic push_fetch(input logic [31:0] a);
        fq.push_back(a);
        fexp.push_back(mread(a));
    endtask

    task automatic push_data(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d);
        dreq_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
        dq.push_back(r);
        if (!wr) last_load = mread(a);
        mexp.push_back(last_load);
    endtask

    task automatic push_gnt(input logic [31:0] a, input logic we);
        gnt_t g;
        g.addr = a; g.we = we;
        gexp.push_back(g);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < budget) begin
            @(negedge clk);
            n++;
            pend = fq.size() + dq.size() + fexp.size() + mexp.size() + gexp.size()
                 + int'(if_req) + int'(mem_rd) + int'(mem_wr) + int'(m_req);
        end
        if (pend != 0) chk("idle_timeout", 32'(pend), 32'd0);
    endtask

    // fetch requester: drops (or replaces) its request in the ack cycle
    initial begin
        if_req = 1'b0; if_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                if_req = 1'b0;
            end else begin
                if (if_req && if_ack) if_req = 1'b0;
                if (!if_req && fq.size() > 0) begin
                    if_addr = fq.pop_front();
                    if_req  = 1'b1;
                end
            end
        end
    end

    // data requester
    initial begin
        dreq_t r;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                mem_rd = 1'b0; mem_wr = 1'b0;
            end else begin
                if ((mem_rd || mem_wr) && mem_ack) begin
                    mem_rd = 1'b0; mem_wr = 1'b0;
                end
                if (!(mem_rd || mem_wr) && dq.size() > 0) begin
                    r = dq.pop_front();
                    mem_rd = r.rd; mem_wr = r.wr; mem_addr = r.addr; mem_wdata = r.wdata;
                end
            end
        end
    end

    // memory model: answers after mem_wait idle BUSY cycles
    initial begin
        int wcnt;
        wcnt = 0;
        m_ready = 1'b0; m_rdata = '0;
        mem[32'h10] = 32'h2002_0005;
        forever begin
            @(posedge clk); #1;
            if (!auto_mem) begin
                m_ready = force_ready;
                m_rdata = 32'hBAD0_BAD0;
                wcnt = 0;
            end else if (m_req && !m_ready) begin
                if (wcnt >= mem_wait) begin
                    m_ready = 1'b1;
                    wcnt = 0;
                    if (m_we) begin
                        mem[m_addr] = m_wdata;
                        m_rdata = 32'hFFFF_FFFF;
                    end else begin
                        m_rdata = mread(m_addr);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                m_ready = 1'b0;
            end
        end
    end

    // monitor: grant order, request stability, ack data
    logic        p_req = 1'b0, p_rdy = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;
    initial begin
        gnt_t g;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (p_req && !p_rdy) begin
                    chk("m_req_hold", 32'(m_req), 32'd1);
                    chk("m_addr_hold", m_addr, p_addr);
                    chk("m_we_hold", 32'(m_we), 32'(p_we));
                    chk("m_wdata_hold", m_wdata, p_wd);
                end
                if (m_req && !p_req) begin
                    if (gexp.size() == 0) chk("grant_spurious", 32'(gexp.size()), 32'd1);
                    else begin
                        g = gexp.pop_front();
                        chk("grant_addr", m_addr, g.addr);
                        chk("grant_we", 32'(m_we), 32'(g.we));
                    end
                end
                if (if_ack) begin
                    if (fexp.size() == 0) chk("if_ack_spurious", 32'(fexp.size()), 32'd1);
                    else chk("if_rdata", if_rdata, fexp.pop_front());
                end
                if (mem_ack) begin
                    if (mexp.size() == 0) chk("mem_ack_spurious", 32'(mexp.size()), 32'd1);
                    else chk("mem_rdata", mem_rdata, mexp.pop_front());
                end
            end
            p_req  = reset ? 1'b0 : m_req;
            p_rdy  = m_ready;
            p_we   = m_we;
            p_addr = m_addr;
            p_wd   = m_wdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_mem_ack", 32'(mem_ack), 32'd0);
        chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
        chk("rst_stalls", {30'd0, freeze, stall_mem}, 32'd0);

        // single fetch, cycle-accurate
        push_fetch(32'h10);
        push_gnt(32'h10, 1'b0);
        @(negedge clk);
        chk("f_c0_freeze", 32'(freeze), 32'd1);
        chk("f_c0_m_req", 32'(m_req), 32'd0);
        @(negedge clk);
        chk("f_c1_m_req", 32'(m_req), 32'd1);
        chk("f_c1_m_addr", m_addr, 32'h10);
        chk("f_c1_freeze", 32'(freeze), 32'd1);
        @(negedge clk);
        chk("f_c2_if_ack", 32'(if_ack), 32'd1);
        chk("f_c2_if_rdata", if_rdata, 32'h2002_0005);
        chk("f_c2_freeze", 32'(freeze), 32'd0);
        wait_idle(20);

        // collision: data first, stall_mem releases before freeze
        push_data(1'b1, 1'b0, 32'h100, 32'h0);
        push_fetch(32'h200);
        push_gnt(32'h100, 1'b0);
        push_gnt(32'h200, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_ack && n < 20);
        chk("col_mem_ack", 32'(mem_ack), 32'd1);
        chk("col_stall_mem", 32'(stall_mem), 32'd0);
        chk("col_freeze_held", 32'(freeze), 32'd1);
        wait_idle(20);

        // store with three wait cycles
        mem_wait = 3;
        push_data(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        push_gnt(32'h40, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        chk("st_m_we", 32'(m_we), 32'd1);
        chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
        n = 0;
        while (m_req && n < 20) begin n++; @(negedge clk); end
        chk("st_busy_cycles", 32'(n), 32'd4);
        wait_idle(20);
        mem_wait = 0;
        push_data(1'b1, 1'b0, 32'h40, 32'h0);
        push_gnt(32'h40, 1'b0);
        wait_idle(20);

        // starvation guard: 4 data grants, then the fetch is forced
        push_fetch(32'h300);
        for (int i = 0; i < 6; i++) push_data(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h0);
        for (int i = 0; i < 4; i++) push_gnt(32'h400 + 32'(4 * i), 1'b0);
        push_gnt(32'h300, 1'b0);
        push_gnt(32'h410, 1'b0);
        push_gnt(32'h414, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(m_req && m_addr == 32'h300) && n < 60);
        chk("stv_fetch_grant", m_addr, 32'h300);
        chk("stv_burst_clr", 32'(dut.u_burst.cnt), 32'd0);
        wait_idle(60);

        // rd and wr together: store, mem_rdata untouched
        push_data(1'b1, 1'b1, 32'h44, 32'h1234);
        push_gnt(32'h44, 1'b1);
        wait_idle(20);
        push_data(1'b1, 1'b0, 32'h44, 32'h0);
        push_gnt(32'h44, 1'b0);
        wait_idle(20);

        // reset in DATA_BUSY, m_ready arrives afterwards
        auto_mem = 1'b0;
        dq.push_back({1'b1, 1'b0, 32'h80, 32'h0});
        push_gnt(32'h80, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        chk("rm_busy", 32'(dut.state), 32'(ARB_DATA_BUSY));
        @(posedge clk); #2;
        reset = 1'b1;
        force_ready = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        last_load = '0;
        @(negedge clk);
        chk("rm_m_req", 32'(m_req), 32'd0);
        chk("rm_m_addr", m_addr, 32'd0);
        chk("rm_mem_ack", 32'(mem_ack), 32'd0);
        @(negedge clk);
        force_ready = 1'b0;
        chk("rm_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("rm_mem_ack2", 32'(mem_ack), 32'd0);
        chk("rm_m_we_wdata", {31'd0, m_we} | m_wdata, 32'd0);
        chk("rm_rdata", if_rdata | mem_rdata, 32'd0);
        chk("rm_m_req2", 32'(m_req), 32'd0);
        repeat (2) @(negedge clk);
        auto_mem = 1'b1;
        push_data(1'b1, 1'b0, 32'h40, 32'h0);
        push_gnt(32'h40, 1'b0);
        wait_idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
